calendar_gregorian: RTL and testbench
=====================================

# calendar_gregorian

Parametrised date counter for the digital clock. It holds day, month, year and, optionally, day-of-week. It advances on the clock module's end-of-day strobe and applies the full Gregorian leap-year rule against a configurable base year. Its user-edit path clamps the day, and a validated parallel load lets the date be preset. It sits between the time-of-day counter and the display/format logic, and runs on the system clock with a tick qualifier, not on a derived clock.

## Interface
- YEAR_BASE, 2000: absolute year represented by year==0; used only for the leap rule.
- YEAR_W, 8: width of the year offset register.
- YEAR_MAX, 99: largest year offset; must be < 2**YEAR_W.
- DEFAULT_DAY, 1 / DEFAULT_MONTH, 9 / DEFAULT_YEAR, 23: reset date.
- DEFAULT_DOW, 5: reset day-of-week (0=Sunday … 6=Saturday).

Ports:
- clk  in  1: system clock; all state changes on its rising edge.
- reset  in  1: asynchronous, active-high.
- tick_en  in  1: qualifier; `end_of_day` and the `inc_*` inputs are sampled only when it is high.
- end_of_day  in  1: day rollover strobe from the clock module.
- inc_day, inc_month, inc_year  in  1 each: user edit buttons, already debounced and edge-detected.
- load  in  1: parallel preset; acts regardless of `tick_en`.
- load_day  in  5, load_month  in  4, load_year  in  YEAR_W, load_dow  in  3: preset values.
- day  out  5, month  out  4, year  out  YEAR_W: registered binary date.
- dow  out  3: registered day-of-week (only with `CALENDAR_DOW_EN`).
- end_of_month  out  1, end_of_year  out  1: one-clk registered pulses.
- load_err  out  1: one-clk registered pulse when a load is rejected.

## Operation
- Leap rule: `full = YEAR_BASE + year`. The year is a leap year when `full % 4 == 0` and (`full % 100 != 0` or `full % 400 == 0`).
- `mlen(m, y)`: 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for months 4, 6, 9, 11; 29 for month 2 in a leap year, otherwise 28.
- Per clk, at most one action is applied. Priority: load > inc_year > inc_month > inc_day > end_of_day. Lower-priority requests in the same cycle are dropped.
- **load:** accepted when `1 <= load_month <= 12`, `1 <= load_day <= mlen(load_month, load_year)` and `load_year <= YEAR_MAX`.
  - If accepted, all fields are written.
  - If rejected, the date is unchanged and `load_err` pulses.
- **inc_day:** `day = (day == mlen) ? 1 : day + 1`. No carry into month.
- **inc_month:** month wraps 12→1. Day is clamped to `mlen` of the new month. No carry into year.
- **inc_year:** year wraps YEAR_MAX→0. A 29/02 date is clamped to 28/02 when the new year is not a leap year.
- **end_of_day:** full carry chain.
  - If `day < mlen`: `day + 1`.
  - Otherwise: `day = 1`, month advances, and `end_of_month` pulses.
  - If month was 12: `month = 1`, year advances (wrapping YEAR_MAX→0), and `end_of_year` also pulses.
- **dow:** advances mod 7 only on `end_of_day`. It is written by an accepted load. It is not changed by `inc_*`.
- Illegal held state (for example month 0 after an SEU) is recovered on the next `end_of_day` to 01/01 of the same year.

## Timing
- Reset values: `day`/`month`/`year`/`dow` take their DEFAULT_* parameters. `end_of_month`, `end_of_year` and `load_err` are 0.
- Reset asserted mid-operation clears pending pulses immediately.
- Latency: the new date is visible 1 clk after the qualifying edge.
- Pulses are high for exactly the clk following the update that caused them, and never for more than 1 clk.
- `end_of_day` held high across several `tick_en` cycles advances once per qualified cycle; the block does no edge detection.

## Configuration
- `CALENDAR_DOW_EN` defined: the `dow` register, `load_dow` and the weekday logic are present.
- Not defined: `dow` is driven constant 0, `load_dow` is ignored, and no weekday flops are synthesised.

## Test plan
- Assert reset mid-count at 15/06/40 → next clk shows 01/09/23, dow 5, all pulses 0.
- Year 24 (2024), 28/02, `end_of_day` ×2 → 29/02, then 01/03 with a single `end_of_month` pulse.
- YEAR_BASE=2000, YEAR_MAX=255: 28/02/100 (2100) + `end_of_day` → 01/03 (not leap); 28/02/0 (2000) + `end_of_day` → 29/02 (leap).
- 31/12/99 + `end_of_day` → 01/01/00; `end_of_month` and `end_of_year` each high for 1 clk.
- Clamping and priority:
  - 31/01/23 + `inc_month` → 28/02/23.
  - 29/02/24 + `inc_year` → 28/02/25.
  - `inc_day` and `end_of_day` together at 30/04 → 01/04 (only `inc_day` applied).
- Load 31/04/30 → rejected, `load_err` 1 clk, date unchanged. Load 29/02/24 with dow 4 → accepted; `end_of_day` → 01/03/24, dow 5 (with `CALENDAR_DOW_EN`).

Source files
------------

// File: rtl/calendar_gregorian.sv
// Day/month/year date counter with the Gregorian leap rule, clamped user edits and a
// validated preset. The weekday register exists only when CALENDAR_DOW_EN is defined.
module calendar_gregorian #(
    parameter int YEAR_BASE     = 2000,
    parameter int YEAR_W        = 8,
    parameter int YEAR_MAX      = 99,
    parameter int DEFAULT_DAY   = 1,
    parameter int DEFAULT_MONTH = 9,
    parameter int DEFAULT_YEAR  = 23,
    parameter int DEFAULT_DOW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_en,
    input  logic              end_of_day,
    input  logic              inc_day,
    input  logic              inc_month,
    input  logic              inc_year,
    input  logic              load,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [2:0]        load_dow,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [2:0]        dow,
    output logic              end_of_month,
    output logic              end_of_year,
    output logic              load_err
);
    localparam logic [YEAR_W-1:0] YMAX = YEAR_MAX[YEAR_W-1:0];

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        int full;
        full = YEAR_BASE + int'(y);
        return (full % 4 == 0) && ((full % 100 != 0) || (full % 400 == 0));
    endfunction

    function automatic logic [4:0] mlen(input logic [3:0] m, input logic [YEAR_W-1:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: mlen = 5'd30;
            4'd2:                    mlen = is_leap(y) ? 5'd29 : 5'd28;
            default:                 mlen = 5'd31;
        endcase
    endfunction

    logic [4:0]        cur_len, inc_m_len, inc_y_len, load_len;
    logic [3:0]        month_next;
    logic [YEAR_W-1:0] year_next;
    logic              date_legal, load_ok;

    always_comb begin
        year_next  = (year >= YMAX) ? '0 : year + YEAR_W'(1);
        month_next = (month >= 4'd12) ? 4'd1 : month + 4'd1;
        cur_len    = mlen(month, year);
        inc_m_len  = mlen(month_next, year);
        inc_y_len  = mlen(month, year_next);
        load_len   = mlen(load_month, load_year);
        date_legal = (month != 4'd0) && (month <= 4'd12) && (day != 5'd0) && (day <= cur_len);
        load_ok    = (load_month != 4'd0) && (load_month <= 4'd12) && (load_day != 5'd0)
                     && (load_day <= load_len) && (load_year <= YMAX);
    end

    // One action per clock: load, then inc_year, inc_month, inc_day, end_of_day.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            day          <= DEFAULT_DAY[4:0];
            month        <= DEFAULT_MONTH[3:0];
            year         <= DEFAULT_YEAR[YEAR_W-1:0];
            end_of_month <= 1'b0;
            end_of_year  <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            end_of_month <= 1'b0;
            end_of_year  <= 1'b0;
            load_err     <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    day   <= load_day;
                    month <= load_month;
                    year  <= load_year;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick_en) begin
                if (inc_year) begin
                    year <= year_next;
                    if (day > inc_y_len) day <= inc_y_len;
                end else if (inc_month) begin
                    month <= month_next;
                    if (day > inc_m_len) day <= inc_m_len;
                end else if (inc_day) begin
                    day <= (day >= cur_len) ? 5'd1 : day + 5'd1;
                end else if (end_of_day) begin
                    if (!date_legal) begin
                        // Corrupted date: restart at 1 January of the held year.
                        day   <= 5'd1;
                        month <= 4'd1;
                    end else if (day < cur_len) begin
                        day <= day + 5'd1;
                    end else begin
                        day          <= 5'd1;
                        end_of_month <= 1'b1;
                        if (month == 4'd12) begin
                            month       <= 4'd1;
                            year        <= year_next;
                            end_of_year <= 1'b1;
                        end else begin
                            month <= month + 4'd1;
                        end
                    end
                end
            end
        end
    end

`ifdef CALENDAR_DOW_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dow <= DEFAULT_DOW[2:0];
        end else if (load) begin
            if (load_ok) dow <= load_dow;
        end else if (tick_en && end_of_day && !inc_year && !inc_month && !inc_day) begin
            dow <= (dow >= 3'd6) ? 3'd0 : dow + 3'd1;
        end
    end
`else
    logic unused_dow_cfg;
    assign unused_dow_cfg = ^load_dow;
    assign dow = 3'd0;
`endif

endmodule

// File: tb/tb_calendar_gregorian.sv
// Bench for calendar_gregorian: directed vector table, hand-written multi-cycle sequences,
// and a randomized run against a day/month/year reference model.
module tb_calendar_gregorian;
`ifdef CALENDAR_DOW_EN
    localparam bit DOW_EN = 1'b1;
`else
    localparam bit DOW_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, tick_en, end_of_day, inc_day, inc_month, inc_year, load;
    logic [4:0] load_day;
    logic [3:0] load_month;
    logic [7:0] load_year;
    logic [2:0] load_dow;

    logic [4:0] a_day,   b_day;
    logic [3:0] a_month, b_month;
    logic [7:0] a_year,  b_year;
    logic [2:0] a_dow,   b_dow;
    logic       a_eom, a_eoy, a_err, b_eom, b_eoy, b_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    calendar_gregorian dut (
        .clk(clk), .reset(reset), .tick_en(tick_en), .end_of_day(end_of_day),
        .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year), .load_dow(load_dow),
        .day(a_day), .month(a_month), .year(a_year), .dow(a_dow),
        .end_of_month(a_eom), .end_of_year(a_eoy), .load_err(a_err)
    );

    calendar_gregorian #(.YEAR_MAX(255)) dut255 (
        .clk(clk), .reset(reset), .tick_en(tick_en), .end_of_day(end_of_day),
        .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year), .load_dow(load_dow),
        .day(b_day), .month(b_month), .year(b_year), .dow(b_dow),
        .end_of_month(b_eom), .end_of_year(b_eoy), .load_err(b_err)
    );

    typedef struct {
        string name;
        int    pd, pm, py;
        bit    tick, eod, id, im, iy;
        int    ed, em, ey;
        bit    eom, eoy;
    } vec_t;

    vec_t vecs[$];

    // Reference: month lengths from a table, leap year from the calendar rule.
    function automatic int mdays(int m, int y, int base);
        int tbl[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        int full;
        bit leap;
        if (m < 1 || m > 12) return 0;
        full = base + y;
        leap = (full % 4 == 0) && ((full % 100 != 0) || (full % 400 == 0));
        if (m == 2 && leap) return 29;
        return tbl[m];
    endfunction

    function automatic int xdow(int w);
        return DOW_EN ? w : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_date(input string n, input int d, input int m, input int y, input int w,
                              input bit eom, input bit eoy, input bit err);
        chk({n, ".day"},   32'(a_day),   32'(d));
        chk({n, ".month"}, 32'(a_month), 32'(m));
        chk({n, ".year"},  32'(a_year),  32'(y));
        chk({n, ".dow"},   32'(a_dow),   32'(xdow(w)));
        chk({n, ".eom"},   32'(a_eom),   32'(eom));
        chk({n, ".eoy"},   32'(a_eoy),   32'(eoy));
        chk({n, ".err"},   32'(a_err),   32'(err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        tick_en = 0; end_of_day = 0; inc_day = 0; inc_month = 0; inc_year = 0; load = 0;
    endtask

    task automatic preset(input int d, input int m, input int y, input int w);
        clear();
        load = 1; load_day = 5'(d); load_month = 4'(m); load_year = 8'(y); load_dow = 3'(w);
        step();
        load = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int md, mm, my, mdow;
        bit meom, meoy, merr;
        bit ld, tk, ed, di, dm, dy;
        int rd, rm, ry, rw, e;
        logic [22:0] exp_v;

        vecs.push_back('{"eod_28feb_leap",   28,  2, 24, 1, 1, 0, 0, 0, 29,  2, 24, 0, 0});
        vecs.push_back('{"eod_29feb_leap",   29,  2, 24, 1, 1, 0, 0, 0,  1,  3, 24, 1, 0});
        vecs.push_back('{"eod_28feb_common", 28,  2, 23, 1, 1, 0, 0, 0,  1,  3, 23, 1, 0});
        vecs.push_back('{"eod_31dec_99",     31, 12, 99, 1, 1, 0, 0, 0,  1,  1,  0, 1, 1});
        vecs.push_back('{"eod_30nov",        30, 11,  5, 1, 1, 0, 0, 0,  1, 12,  5, 1, 0});
        vecs.push_back('{"eod_28feb_2000",   28,  2,  0, 1, 1, 0, 0, 0, 29,  2,  0, 0, 0});
        vecs.push_back('{"incm_31jan",       31,  1, 23, 1, 0, 0, 1, 0, 28,  2, 23, 0, 0});
        vecs.push_back('{"incm_31mar",       31,  3,  0, 1, 0, 0, 1, 0, 30,  4,  0, 0, 0});
        vecs.push_back('{"incm_dec_wrap",    12, 12,  5, 1, 0, 0, 1, 0, 12,  1,  5, 0, 0});
        vecs.push_back('{"incy_29feb",       29,  2, 24, 1, 0, 0, 0, 1, 28,  2, 25, 0, 0});
        vecs.push_back('{"incy_wrap",        31, 12, 99, 1, 0, 0, 0, 1, 31, 12,  0, 0, 0});
        vecs.push_back('{"incd_beats_eod",   30,  4, 10, 1, 1, 1, 0, 0,  1,  4, 10, 0, 0});
        vecs.push_back('{"incd_plain",       14,  7, 33, 1, 0, 1, 0, 0, 15,  7, 33, 0, 0});
        vecs.push_back('{"incy_beats_all",   10,  5, 50, 1, 1, 1, 1, 1, 10,  5, 51, 0, 0});
        vecs.push_back('{"no_tick",          15,  6, 40, 0, 1, 1, 1, 1, 15,  6, 40, 0, 0});

        reset = 1;
        clear();
        load_day = 0; load_month = 0; load_year = 0; load_dow = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        #1 check_date("reset", 1, 9, 23, 5, 0, 0, 0);

        foreach (vecs[i]) begin
            preset(vecs[i].pd, vecs[i].pm, vecs[i].py, 3);
            tick_en = vecs[i].tick; end_of_day = vecs[i].eod;
            inc_day = vecs[i].id; inc_month = vecs[i].im; inc_year = vecs[i].iy;
            step();
            clear();
            check_date(vecs[i].name, vecs[i].ed, vecs[i].em, vecs[i].ey,
                       (vecs[i].tick && vecs[i].eod && !vecs[i].id && !vecs[i].im && !vecs[i].iy) ? 4 : 3,
                       vecs[i].eom, vecs[i].eoy, 0);
        end

        // Rejected load leaves the date alone; load_err lasts one clock.
        preset(10, 10, 10, 3);
        load = 1; load_day = 31; load_month = 4; load_year = 30; load_dow = 0;
        step();
        clear();
        check_date("load_rej", 10, 10, 10, 3, 0, 0, 1);
        step();
        check_date("load_rej_after", 10, 10, 10, 3, 0, 0, 0);

        preset(29, 2, 24, 4);
        check_date("load_ok", 29, 2, 24, 4, 0, 0, 0);
        tick_en = 1; end_of_day = 1;
        step();
        clear();
        check_date("load_ok_eod", 1, 3, 24, 5, 1, 0, 0);
        step();
        check_date("eom_one_clk", 1, 3, 24, 5, 0, 0, 0);

        preset(31, 12, 99, 6);
        tick_en = 1; end_of_day = 1;
        step();
        clear();
        check_date("year_wrap", 1, 1, 0, 0, 1, 1, 0);
        step();
        check_date("year_wrap_after", 1, 1, 0, 0, 0, 0, 0);

        // end_of_day held high; only qualified cycles advance.
        preset(27, 2, 23, 1);
        end_of_day = 1;
        tick_en = 1; step(); check_date("held_1", 28, 2, 23, 2, 0, 0, 0);
        tick_en = 0; step(); check_date("held_2", 28, 2, 23, 2, 0, 0, 0);
        tick_en = 1; step(); check_date("held_3",  1, 3, 23, 3, 1, 0, 0);
        tick_en = 1; step(); check_date("held_4",  2, 3, 23, 4, 0, 0, 0);
        clear();

        // Asynchronous reset while an end_of_month pulse is high.
        preset(15, 6, 40, 1);
        preset(30, 6, 40, 2);
        tick_en = 1; end_of_day = 1;
        step();
        clear();
        check_date("pre_reset", 1, 7, 40, 3, 1, 0, 0);
        reset = 1;
        #1 check_date("reset_async", 1, 9, 23, 5, 0, 0, 0);
        step();
        check_date("reset_held", 1, 9, 23, 5, 0, 0, 0);
        reset = 0;

        // Wide year range: 2100 is not leap, 2000 is.
        preset(28, 2, 100, 0);
        chk("y100_rej_small.err", 32'(a_err), 32'd1);
        chk("y100_acc_wide.err",  32'(b_err), 32'd0);
        tick_en = 1; end_of_day = 1; step(); clear();
        chk("y2100.day",   32'(b_day),   32'd1);
        chk("y2100.month", 32'(b_month), 32'd3);
        chk("y2100.year",  32'(b_year),  32'd100);
        preset(28, 2, 0, 0);
        tick_en = 1; end_of_day = 1; step(); clear();
        chk("y2000.day",   32'(b_day),   32'd29);
        chk("y2000.month", 32'(b_month), 32'd2);
        preset(31, 12, 255, 0);
        tick_en = 1; end_of_day = 1; step(); clear();
        chk("y255_wrap.year", 32'(b_year), 32'd0);
        chk("y255_wrap.eoy",  32'(b_eoy),  32'd1);

        // Randomized run against the reference model.
        reset = 1;
        step();
        reset = 0;
        md = 1; mm = 9; my = 23; mdow = 5;
        for (int c = 0; c < 3000; c++) begin
            ld = ($urandom_range(0, 9) == 0);
            tk = ($urandom_range(0, 3) != 0);
            ed = 1'($urandom_range(0, 1));
            di = ($urandom_range(0, 7) == 0);
            dm = ($urandom_range(0, 7) == 0);
            dy = ($urandom_range(0, 7) == 0);
            rd = $urandom_range(0, 31); rm = $urandom_range(0, 15);
            ry = $urandom_range(0, 255); rw = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) begin
                rm = $urandom_range(1, 12); ry = $urandom_range(0, 99);
                rd = $urandom_range(1, mdays(rm, ry, 2000));
            end
            load = ld; tick_en = tk; end_of_day = ed; inc_day = di; inc_month = dm; inc_year = dy;
            load_day = 5'(rd); load_month = 4'(rm); load_year = 8'(ry); load_dow = 3'(rw);

            meom = 0; meoy = 0; merr = 0;
            if (ld) begin
                if (rm >= 1 && rm <= 12 && rd >= 1 && rd <= mdays(rm, ry, 2000) && ry <= 99) begin
                    md = rd; mm = rm; my = ry; mdow = rw;
                end else begin
                    merr = 1;
                end
            end else if (tk) begin
                if (dy) begin
                    my = (my + 1) % 100;
                    if (md > mdays(mm, my, 2000)) md = mdays(mm, my, 2000);
                end else if (dm) begin
                    mm = mm % 12 + 1;
                    if (md > mdays(mm, my, 2000)) md = mdays(mm, my, 2000);
                end else if (di) begin
                    md = md % mdays(mm, my, 2000) + 1;
                end else if (ed) begin
                    mdow = (mdow + 1) % 7;
                    md = md + 1;
                    if (md > mdays(mm, my, 2000)) begin
                        md = 1; meom = 1; mm = mm + 1;
                        if (mm > 12) begin
                            mm = 1; my = (my + 1) % 100; meoy = 1;
                        end
                    end
                end
            end
            step();
            e = xdow(mdow);
            exp_v = {5'(md), 4'(mm), 8'(my), 3'(e), meom, meoy, merr};
            chk($sformatf("rand_%0d", c), 32'({a_day, a_month, a_year, a_dow, a_eom, a_eoy, a_err}),
                32'(exp_v));
        end
        clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
